comparator_1bit: RTL and testbench

- Registered 1-bit magnitude comparator: compares single-bit operands A and B.
- Produces one-hot greater/less/equal flags one clock after sampling.
- Optional saturating per-outcome event counters for statistics and debug.
- Leaf block used wherever bit-level compare results must be pipelined, for example as the slice of a wider comparator chain or a status monitor.

---
 rtl/comparator_1bit.sv | 100 ++++++++++
 tb/tb_comparator_1bit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_1bit.sv
// ============================================================================
// comparator_1bit : registered 1-bit magnitude compare with one-hot G/L/E,
// change pulse and optional saturating outcome counters (COMPARATOR_1BIT_COUNT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module comparator_1bit #(
  parameter int CNT_W  = 8,
  parameter bit RST_EQ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             A,
  input  logic             B,
  input  logic             clr_cnt,
  output logic             G,
  output logic             L,
  output logic             E,
  output logic             vld,
  output logic             chg,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  logic [2:0] gle_d;
  logic [2:0] gle_q;
  logic       vld_q;
  logic       chg_q;

  // Result order is {greater, less, equal}; exactly one bit is ever set.
  assign gle_d = {A & ~B, ~A & B, ~(A ^ B)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gle_q <= {2'b00, RST_EQ};
      vld_q <= 1'b0;
      chg_q <= 1'b0;
    end else if (en) begin
      gle_q <= gle_d;
      vld_q <= 1'b1;
      chg_q <= (gle_d != gle_q);
    end else begin
      vld_q <= 1'b0;
      chg_q <= 1'b0;
    end
  end

  assign G   = gle_q[2];
  assign L   = gle_q[1];
  assign E   = gle_q[0];
  assign vld = vld_q;
  assign chg = chg_q;

`ifdef COMPARATOR_1BIT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counter i tracks outcome bit gle_d[2-i]: 0 = greater, 1 = less, 2 = equal.
  for (genvar i = 0; i < 3; i++) begin : g_cnt
    logic             hit;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign hit = en & gle_d[2-i];

    always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
        cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign gt_cnt = g_cnt[0].cnt_q;
  assign lt_cnt = g_cnt[1].cnt_q;
  assign eq_cnt = g_cnt[2].cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;

  assign gt_cnt = '0;
  assign lt_cnt = '0;
  assign eq_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_comparator_1bit.sv
// ============================================================================
// tb_comparator_1bit : self-checking bench for comparator_1bit (tables, corner
// sequences, randomized run against an arithmetic reference model).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_comparator_1bit;

`ifdef COMPARATOR_1BIT_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam int W1 = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance: CNT_W=8, RST_EQ=1
  logic en, A, B, clr_cnt;
  logic G, L, E, vld, chg;
  logic [W1-1:0] gt_cnt, lt_cnt, eq_cnt;

  // saturation instance: CNT_W=2, RST_EQ=0
  logic en2, A2, B2, clr2;
  logic G2, L2, E2, vld2, chg2;
  logic [W2-1:0] gt2, lt2, eq2;

  comparator_1bit #(.CNT_W(W1), .RST_EQ(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .clr_cnt(clr_cnt),
    .G(G), .L(L), .E(E), .vld(vld), .chg(chg),
    .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
  );

  comparator_1bit #(.CNT_W(W2), .RST_EQ(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .A(A2), .B(B2), .clr_cnt(clr2),
    .G(G2), .L(L2), .E(E2), .vld(vld2), .chg(chg2),
    .gt_cnt(gt2), .lt_cnt(lt2), .eq_cnt(eq2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of u_dut: outcome as an arithmetic relation of A and B.
  int m_rel;         // 0 = greater, 1 = less, 2 = equal, 3 = none (flags clear)
  bit m_vld, m_chg;
  int m_cnt [3];

  typedef struct {
    bit       a;
    bit       b;
    bit [2:0] gle;
    bit       chg;
  } vec_t;

  vec_t sweep [4];
  int   sat_exp [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [2:0] rel_flags(input int r);
    return {r == 0, r == 1, r == 2};
  endfunction

  task automatic model_reset();
    m_rel = 2;
    m_vld = 1'b0;
    m_chg = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input bit e_, input bit a_, input bit b_, input bit c_);
    int r;
    int a_i = int'(a_);
    int b_i = int'(b_);
    r = (a_i > b_i) ? 0 : (a_i < b_i) ? 1 : 2;
    if (c_) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else if (e_ && m_cnt[r] < (2 ** W1) - 1) begin
      m_cnt[r]++;
    end
    if (e_) begin
      m_chg = (r != m_rel);
      m_rel = r;
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
      m_chg = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".GLE"}, {G, L, E}, rel_flags(m_rel));
    chk({tag, ".vld"}, vld, m_vld);
    chk({tag, ".chg"}, chg, m_chg);
    chk({tag, ".gt_cnt"}, gt_cnt, CNT_ON ? m_cnt[0] : 0);
    chk({tag, ".lt_cnt"}, lt_cnt, CNT_ON ? m_cnt[1] : 0);
    chk({tag, ".eq_cnt"}, eq_cnt, CNT_ON ? m_cnt[2] : 0);
  endtask

  task automatic cyc(input string tag, input bit e_, input bit a_, input bit b_, input bit c_);
    en = e_; A = a_; B = b_; clr_cnt = c_;
    model_edge(e_, a_, b_, c_);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic sat_cyc(input bit e_, input bit a_, input bit b_, input bit c_);
    en2 = e_; A2 = a_; B2 = b_; clr2 = c_;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    sweep[0] = '{1'b0, 1'b0, 3'b001, 1'b0};
    sweep[1] = '{1'b0, 1'b1, 3'b010, 1'b1};
    sweep[2] = '{1'b1, 1'b0, 3'b100, 1'b1};
    sweep[3] = '{1'b1, 1'b1, 3'b001, 1'b1};
    sat_exp  = '{1, 2, 3, 3, 3, 3};

    en = 0; A = 0; B = 0; clr_cnt = 0;
    en2 = 0; A2 = 0; B2 = 0; clr2 = 0;
    rst_n = 1'b1;

    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    chk("reset.u_sat.GLE", {G2, L2, E2}, 3'b000);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset_idle");

    // Exhaustive sweep with fixed expectations from the table.
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("sweep%0d", i), 1'b1, sweep[i].a, sweep[i].b, 1'b0);
      chk($sformatf("sweep%0d.tbl_GLE", i), {G, L, E}, sweep[i].gle);
      chk($sformatf("sweep%0d.tbl_chg", i), chg, sweep[i].chg);
      chk($sformatf("sweep%0d.tbl_vld", i), vld, 1'b1);
    end
    chk("sweep.tbl_eq_cnt", eq_cnt, CNT_ON ? 2 : 0);
    chk("sweep.tbl_lt_cnt", lt_cnt, CNT_ON ? 1 : 0);
    chk("sweep.tbl_gt_cnt", gt_cnt, CNT_ON ? 1 : 0);

    // Enable gating: flags hold while en=0 even though inputs change.
    cyc("gate_load", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("gate%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("gate%0d.G", i), G, 1'b1);
    end

    // Asynchronous reset while G=1, released before the next edge.
    cyc("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst_n = 1'b1;
    cyc("post_rst", 1'b1, 1'b0, 1'b1, 1'b0);

    // clr_cnt with en=0 clears counters but leaves flags alone.
    cyc("cnt_up", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("clr_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Saturation on the 2-bit instance; first sample after reset must pulse chg.
    en = 0; clr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sat_cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("sat%0d.eq_cnt", i), eq2, CNT_ON ? sat_exp[i] : 0);
      chk($sformatf("sat%0d.E", i), E2, 1'b1);
      if (i == 0) chk("sat0.first_chg", chg2, 1'b1);
      else        chk($sformatf("sat%0d.chg", i), chg2, 1'b0);
    end
    sat_cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sat_clr.eq_cnt", eq2, 0);
    chk("sat_clr.E", E2, 1'b1);
    chk("sat_clr.vld", vld2, 1'b1);
    sat_cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_after.gt_cnt", gt2, CNT_ON ? 1 : 0);
    chk("sat_after.eq_cnt", eq2, 0);
    chk("sat_after.chg", chg2, 1'b1);
    en2 = 0;

    // Randomized run against the reference model.
    do_reset();
    check_all("rand_start");
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
